// File: rtl/adc_be_seq_if.sv
// Control, configuration and sample-stream bundle between the ADC backend
// sequencer (slave) and whoever drives it (master).
interface adc_be_seq_if;
    logic        enable;
    logic        cfg_req;
    logic        cfg_ack;
    logic [2:0]  cfg_cic_order;
    logic [2:0]  cfg_decim_ratio;
    logic        cfg_bypass_stg2;
    logic        cfg_bypass_noise_gate;
    logic [2:0]  cic_order;
    logic [2:0]  decim_ratio;
    logic        bypass_stg2;
    logic        bypass_noise_gate;
    logic        clear_cic;
    logic        clear_iir_stg1;
    logic        clear_iir_stg2;
    logic        clear_scale_mult;
    logic        clear_noise_gate;
    logic        be_valid;
    logic [15:0] be_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  state;

    modport master (
        output enable, cfg_req, cfg_cic_order, cfg_decim_ratio,
               cfg_bypass_stg2, cfg_bypass_noise_gate, be_valid, be_data,
        input  cfg_ack, cic_order, decim_ratio, bypass_stg2, bypass_noise_gate,
               clear_cic, clear_iir_stg1, clear_iir_stg2, clear_scale_mult,
               clear_noise_gate, out_valid, out_data, state
    );

    modport slave (
        input  enable, cfg_req, cfg_cic_order, cfg_decim_ratio,
               cfg_bypass_stg2, cfg_bypass_noise_gate, be_valid, be_data,
        output cfg_ack, cic_order, decim_ratio, bypass_stg2, bypass_noise_gate,
               clear_cic, clear_iir_stg1, clear_iir_stg2, clear_scale_mult,
               clear_noise_gate, out_valid, out_data, state
    );
endinterface

// File: rtl/adc_be_seq.sv
// ADC backend sequencer: holds the filter chain cleared, lets it settle by
// dropping the first DISCARD samples, then passes samples; reconfig restarts.
module adc_be_seq #(
    parameter int CLR_CYC = 4,
    parameter int DISCARD = 8
) (
    input logic         clk,
    input logic         rst,
    adc_be_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, SETTLE = 2'd2, RUN = 2'd3} state_e;

    localparam logic [3:0] CLR_LOAD = 4'(CLR_CYC - 1);
    localparam logic [8:0] DISC_N   = 9'(DISCARD);
    localparam bit         NO_DISC  = (DISCARD == 0);

    state_e      state_q, state_d;
    logic [3:0]  clr_cnt_q, clr_cnt_d;
    logic [7:0]  disc_cnt_q, disc_cnt_d;
    logic [8:0]  disc_nxt;
    logic        ack_q, ack_d;
    logic        clear_q, clear_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic [2:0]  cic_q, cic_d, dec_q, dec_d;
    logic        b2_q, b2_d, bng_q, bng_d;
    logic        cap;

    // A request seen during the ack cycle is the same request still held high.
    assign cap      = bus.cfg_req & ~ack_q;
    assign disc_nxt = {1'b0, disc_cnt_q} + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else if (cap) begin
            state_d = (state_q == IDLE) ? IDLE : CLEAR;
        end else begin
            case (state_q)
                IDLE:    state_d = CLEAR;
                CLEAR:   if (clr_cnt_q == 4'd0) state_d = SETTLE;
                SETTLE:  if (NO_DISC || (bus.be_valid && disc_nxt >= DISC_N)) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        ack_d       = cap;
        cic_d       = cap ? bus.cfg_cic_order : cic_q;
        dec_d       = cap ? bus.cfg_decim_ratio : dec_q;
        b2_d        = cap ? bus.cfg_bypass_stg2 : b2_q;
        bng_d       = cap ? bus.cfg_bypass_noise_gate : bng_q;
        clear_d     = (state_d == IDLE) || (state_d == CLEAR);
        // Pass decision uses the current state so a sample coinciding with a restart is kept.
        out_valid_d = (state_q == RUN) && bus.be_valid;
        out_data_d  = out_valid_d ? bus.be_data : out_data_q;

        clr_cnt_d = clr_cnt_q;
        if (state_d == CLEAR && (state_q != CLEAR || cap)) begin
            clr_cnt_d = CLR_LOAD;
        end else if (state_q == CLEAR && clr_cnt_q != 4'd0) begin
            clr_cnt_d = clr_cnt_q - 4'd1;
        end

        disc_cnt_d = 8'd0;
        if (state_q == SETTLE && state_d == SETTLE) begin
            disc_cnt_d = (bus.be_valid && disc_cnt_q != 8'hFF) ? disc_cnt_q + 8'd1 : disc_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt_q   <= 4'd0;
            disc_cnt_q  <= 8'd0;
            ack_q       <= 1'b0;
            clear_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'd0;
            cic_q       <= 3'd2;
            dec_q       <= 3'd0;
            b2_q        <= 1'b0;
            bng_q       <= 1'b0;
        end else begin
            clr_cnt_q   <= clr_cnt_d;
            disc_cnt_q  <= disc_cnt_d;
            ack_q       <= ack_d;
            clear_q     <= clear_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cic_q       <= cic_d;
            dec_q       <= dec_d;
            b2_q        <= b2_d;
            bng_q       <= bng_d;
        end
    end

    assign bus.cfg_ack           = ack_q;
    assign bus.cic_order         = cic_q;
    assign bus.decim_ratio       = dec_q;
    assign bus.bypass_stg2       = b2_q;
    assign bus.bypass_noise_gate = bng_q;
    assign bus.clear_cic         = clear_q;
    assign bus.clear_iir_stg1    = clear_q;
    assign bus.clear_iir_stg2    = clear_q;
    assign bus.clear_scale_mult  = clear_q;
    assign bus.clear_noise_gate  = clear_q;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_data          = out_data_q;
    assign bus.state             = state_q;
endmodule

// File: tb/tb_adc_be_seq.sv
// Bench for adc_be_seq: hand-derived vector table, corner sequences and a
// randomized run, with two builds (default and DISCARD=0) tracked by a model.
`timescale 1ns/1ps
module tb_adc_be_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_be_seq_if b0 ();
    adc_be_seq_if b1 ();

    assign b1.enable                = b0.enable;
    assign b1.cfg_req               = b0.cfg_req;
    assign b1.cfg_cic_order         = b0.cfg_cic_order;
    assign b1.cfg_decim_ratio       = b0.cfg_decim_ratio;
    assign b1.cfg_bypass_stg2       = b0.cfg_bypass_stg2;
    assign b1.cfg_bypass_noise_gate = b0.cfg_bypass_noise_gate;
    assign b1.be_valid              = b0.be_valid;
    assign b1.be_data               = b0.be_data;

    adc_be_seq #(.CLR_CYC(4), .DISCARD(8)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    adc_be_seq #(.CLR_CYC(3), .DISCARD(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int nchk = 0;
    int nerr = 0;

    // {state, 5 clears, ack, out_valid, out_data, cic, decim, byp2, bypng}
    logic [32:0] act0, act1;
    assign act0 = {b0.state, b0.clear_cic, b0.clear_iir_stg1, b0.clear_iir_stg2, b0.clear_scale_mult,
                   b0.clear_noise_gate, b0.cfg_ack, b0.out_valid, b0.out_data, b0.cic_order,
                   b0.decim_ratio, b0.bypass_stg2, b0.bypass_noise_gate};
    assign act1 = {b1.state, b1.clear_cic, b1.clear_iir_stg1, b1.clear_iir_stg2, b1.clear_scale_mult,
                   b1.clear_noise_gate, b1.cfg_ack, b1.out_valid, b1.out_data, b1.cic_order,
                   b1.decim_ratio, b1.bypass_stg2, b1.bypass_noise_gate};

    localparam logic [32:0] RST_VEC = {2'd0, 5'h1F, 1'b0, 1'b0, 16'h0000, 3'd2, 3'd0, 1'b0, 1'b0};

    // Reference: phase number, cycles already spent clearing, samples dropped so far.
    typedef struct {
        int        st;
        int        celap;
        int        drops;
        bit        ack;
        bit [2:0]  cic;
        bit [2:0]  dec;
        bit        b2;
        bit        bng;
        bit        ov;
        bit [15:0] od;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.st = 0; r.celap = 0; r.drops = 0; r.ack = 1'b0;
        r.cic = 3'd2; r.dec = 3'd0; r.b2 = 1'b0; r.bng = 1'b0;
        r.ov = 1'b0; r.od = 16'h0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int clr_cyc, int discard);
        mdl_t n = m;
        bit cap = b0.cfg_req && !m.ack;
        n.ack = cap;
        if (cap) begin
            n.cic = b0.cfg_cic_order;
            n.dec = b0.cfg_decim_ratio;
            n.b2  = b0.cfg_bypass_stg2;
            n.bng = b0.cfg_bypass_noise_gate;
        end
        n.ov = (m.st == 3) && b0.be_valid;
        if (n.ov) n.od = b0.be_data;
        if (!b0.enable)   n.st = 0;
        else if (cap)     n.st = (m.st == 0) ? 0 : 1;
        else if (m.st == 0) n.st = 1;
        else if (m.st == 1) n.st = (m.celap + 1 >= clr_cyc) ? 2 : 1;
        else if (m.st == 2) n.st = (discard == 0 || (b0.be_valid && m.drops + 1 >= discard)) ? 3 : 2;
        n.celap = (n.st == 1 && m.st == 1 && !cap) ? m.celap + 1 : 0;
        n.drops = (n.st == 2 && m.st == 2) ? m.drops + int'(b0.be_valid) : 0;
        return n;
    endfunction

    function automatic logic [32:0] mpack(mdl_t m);
        return {2'(m.st), {5{m.st <= 1}}, m.ack, m.ov, m.od, m.cic, m.dec, m.b2, m.bng};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= mdl_reset();
            m1 <= mdl_reset();
        end else begin
            m0 <= mdl_step(m0, 4, 8);
            m1 <= mdl_step(m1, 3, 0);
        end
    end

    task automatic cmp(input string name, input logic [32:0] act, input logic [32:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cmp("model_dflt", act0, mpack(m0));
        cmp("model_disc0", act1, mpack(m1));
    endtask

    task automatic drive(input int en, input int req, input int cic, input int dec,
                         input int b2, input int bv, input int bd);
        b0.enable                = 1'(en);
        b0.cfg_req               = 1'(req);
        b0.cfg_cic_order         = 3'(cic);
        b0.cfg_decim_ratio       = 3'(dec);
        b0.cfg_bypass_stg2       = 1'(b2);
        b0.cfg_bypass_noise_gate = 1'b0;
        b0.be_valid              = 1'(bv);
        b0.be_data               = 16'(bd);
    endtask

    typedef struct {
        int n; int en; int req; int cic; int dec; int b2; int bv; int bd;
        int est; int eclr; int eack; int eov; int eod; int ecic; int edec; int eb2;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(int n, int en, int req, int cic, int dec, int b2, int bv, int bd,
                                int est, int eclr, int eack, int eov, int eod, int ecic, int edec, int eb2);
        vec_t v;
        v.n = n; v.en = en; v.req = req; v.cic = cic; v.dec = dec; v.b2 = b2; v.bv = bv; v.bd = bd;
        v.est = est; v.eclr = eclr; v.eack = eack; v.eov = eov; v.eod = eod;
        v.ecic = ecic; v.edec = edec; v.eb2 = eb2;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [31:0] expv;
        // startup: 4 clear cycles, 8 drops, 9th sample passed
        add(1, 1,0,0,0,0, 0,0,       1,1,0,0,0,       2,0,0);
        add(3, 1,0,0,0,0, 0,0,       1,1,0,0,0,       2,0,0);
        add(1, 1,0,0,0,0, 0,0,       2,0,0,0,0,       2,0,0);
        add(7, 1,0,0,0,0, 1,'h5555,  2,0,0,0,0,       2,0,0);
        add(1, 1,0,0,0,0, 1,'h5555,  3,0,0,0,0,       2,0,0);
        add(1, 1,0,0,0,0, 1,'h1234,  3,0,0,1,'h1234,  2,0,0);
        add(2, 1,0,0,0,0, 0,0,       3,0,0,0,'h1234,  2,0,0);
        // reconfig in RUN, coincident sample still passed, then full restart
        add(1, 1,1,5,3,0, 1,'hBEEF,  1,1,1,1,'hBEEF,  5,3,0);
        add(3, 1,0,0,0,0, 0,0,       1,1,0,0,'hBEEF,  5,3,0);
        add(1, 1,0,0,0,0, 0,0,       2,0,0,0,'hBEEF,  5,3,0);
        add(7, 1,0,0,0,0, 1,'h1111,  2,0,0,0,'hBEEF,  5,3,0);
        add(1, 1,0,0,0,0, 1,'h1111,  3,0,0,0,'hBEEF,  5,3,0);
        add(1, 1,0,0,0,0, 1,'h2222,  3,0,0,1,'h2222,  5,3,0);
        // enable drop in SETTLE after 3 drops, then full re-run
        add(1, 0,0,0,0,0, 0,0,       0,1,0,0,'h2222,  5,3,0);
        add(1, 1,0,0,0,0, 0,0,       1,1,0,0,'h2222,  5,3,0);
        add(3, 1,0,0,0,0, 0,0,       1,1,0,0,'h2222,  5,3,0);
        add(1, 1,0,0,0,0, 0,0,       2,0,0,0,'h2222,  5,3,0);
        add(3, 1,0,0,0,0, 1,'h3333,  2,0,0,0,'h2222,  5,3,0);
        add(1, 0,0,0,0,0, 0,0,       0,1,0,0,'h2222,  5,3,0);
        add(1, 1,0,0,0,0, 0,0,       1,1,0,0,'h2222,  5,3,0);
        add(3, 1,0,0,0,0, 0,0,       1,1,0,0,'h2222,  5,3,0);
        add(1, 1,0,0,0,0, 0,0,       2,0,0,0,'h2222,  5,3,0);
        add(7, 1,0,0,0,0, 1,'h3333,  2,0,0,0,'h2222,  5,3,0);
        add(1, 1,0,0,0,0, 1,'h3333,  3,0,0,0,'h2222,  5,3,0);
        add(1, 1,0,0,0,0, 1,'h4444,  3,0,0,1,'h4444,  5,3,0);
        // capture while disabled: ack + shadow load, stays IDLE with clears high
        add(1, 0,0,0,0,0, 0,0,       0,1,0,0,'h4444,  5,3,0);
        add(1, 0,1,5,3,1, 0,0,       0,1,1,0,'h4444,  5,3,1);
        add(1, 0,0,0,0,0, 0,0,       0,1,0,0,'h4444,  5,3,1);

        drive(0,0,0,0,0,0,0);
        @(negedge clk);
        cmp("reset_dflt", act0, RST_VEC);
        cmp("reset_disc0", act1, RST_VEC);
        rst = 1'b0;
        tick();
        cmp("idle_no_enable", {31'd0, b0.state}, 33'd0);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].n; r++) begin
                drive(tbl[i].en, tbl[i].req, tbl[i].cic, tbl[i].dec, tbl[i].b2, tbl[i].bv, tbl[i].bd);
                tick();
                expv = {2'(tbl[i].est), {5{1'(tbl[i].eclr)}}, 1'(tbl[i].eack), 1'(tbl[i].eov),
                        16'(tbl[i].eod), 3'(tbl[i].ecic), 3'(tbl[i].edec), 1'(tbl[i].eb2)};
                cmp($sformatf("tbl%0d_%0d", i, r), {1'b0, act0[32:1]}, {1'b0, expv});
            end
        end

        // DISCARD=0 build: first SETTLE-cycle sample dropped, first RUN sample passed
        drive(1,0,0,0,0,0,0);
        tick(); tick(); tick();
        cmp("d0_clear", {31'd0, b1.state}, 33'd1);
        tick();
        cmp("d0_settle", {31'd0, b1.state}, 33'd2);
        drive(1,0,0,0,0,1,'hAAAA);
        tick();
        cmp("d0_drop", {14'd0, b1.state, b1.out_valid, b1.out_data}, {14'd0, 2'd3, 1'b0, 16'h4444});
        drive(1,0,0,0,0,1,'hBBBB);
        tick();
        cmp("d0_pass", {14'd0, b1.state, b1.out_valid, b1.out_data}, {14'd0, 2'd3, 1'b1, 16'hBBBB});

        // async reset during a passed sample in RUN, with a request raised under reset
        for (int k = 0; k < 14; k++) begin
            drive(1,0,0,0,0,1,k);
            tick();
        end
        cmp("run_before_rst", {31'd0, b0.state}, 33'd3);
        drive(1,0,0,0,0,1,'hCAFE);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        cmp("rst_async_dflt", act0, RST_VEC);
        cmp("rst_async_disc0", act1, RST_VEC);
        b0.cfg_req = 1'b1;
        tick();
        cmp("rst_hold", act0, RST_VEC);
        rst = 1'b0;
        drive(0,0,0,0,0,0,0);
        tick();
        cmp("no_ack_after_rst", {32'd0, b0.cfg_ack}, 33'd0);

        // randomized run; both builds tracked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            rst = 1'b0;
            b0.enable                = ($urandom_range(0, 127) != 0);
            b0.cfg_req               = ($urandom_range(0, 63) == 0) || (b0.cfg_req && !b0.cfg_ack);
            b0.cfg_cic_order         = 3'($urandom);
            b0.cfg_decim_ratio       = 3'($urandom);
            b0.cfg_bypass_stg2       = 1'($urandom);
            b0.cfg_bypass_noise_gate = 1'($urandom);
            b0.be_valid              = 1'($urandom);
            b0.be_data               = 16'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #($urandom_range(1, 4));
                rst = 1'b1;
            end
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/adc_be_seq.md
ADC_BE_SEQ -- requirements
Module: adc_be_seq

Interface
REQ-001 Parameter CLR_CYC, default 4: cycles all stage clears stay high in CLEAR (range 1..15).
REQ-002 Parameter DISCARD, default 8: backend output samples dropped after each restart (range 0..255).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  level; 1 = run backend, 0 = hold backend cleared.
REQ-006 cfg_req  input  1  request to load new configuration; held until cfg_ack.
REQ-007 cfg_ack  output  1  one-cycle pulse: configuration captured.
REQ-008 cfg_cic_order  input  3 / cfg_decim_ratio  input  3 / cfg_bypass_stg2  input  1 / cfg_bypass_noise_gate  input  1  requested configuration, sampled only when captured.
REQ-009 cic_order  output  3 / decim_ratio  output  3 / bypass_stg2  output  1 / bypass_noise_gate  output  1  registered shadow configuration driving the backend.
REQ-010 clear_cic, clear_iir_stg1, clear_iir_stg2, clear_scale_mult, clear_noise_gate  output  1 each  registered stage clears, always equal.
REQ-011 be_valid  input  1 / be_data  input  16  backend output sample strobe and value.
REQ-012 out_valid  output  1 / out_data  output  16  gated sample stream.
REQ-013 state  output  2  IDLE=0, CLEAR=1, SETTLE=2, RUN=3.

Function
REQ-014 FSM shall have states IDLE, CLEAR, SETTLE, RUN; all outputs registered.
REQ-015 Clears shall be 1 in IDLE and CLEAR, 0 in SETTLE and RUN (registered: value follows state of the same cycle).
REQ-016 IDLE -> CLEAR when enable=1 and no capture pending; any state -> IDLE on the cycle after enable sampled 0 (enable has priority over all transitions).
REQ-017 CLEAR shall last exactly CLR_CYC cycles, then -> SETTLE.
REQ-018 SETTLE shall count be_valid pulses, drop them, and -> RUN on the cycle after the DISCARD-th dropped pulse; DISCARD=0 -> RUN after one SETTLE cycle.
REQ-019 RUN: each be_valid sample shall appear as out_valid=1 with out_data=be_data one cycle later; out_data holds last passed value otherwise.
REQ-020 out_valid shall never be 1 outside RUN-passed samples; be_valid in IDLE/CLEAR ignored.
REQ-021 Capture: cfg_req sampled 1 while cfg_ack=0 -> next cycle cfg_ack=1 and shadow config = cfg_* inputs of the sampling cycle; cfg_req sampled while cfg_ack=1 ignored.
REQ-022 Capture in SETTLE or RUN with enable=1 shall restart: state -> CLEAR on the ack cycle, CLEAR counter and discard counter reloaded.
REQ-023 Capture in CLEAR shall reload the CLEAR counter (full CLR_CYC after ack).
REQ-024 Capture in IDLE or with enable=0 shall ack and load shadow, state stays/goes IDLE.
REQ-025 Capture and enable fall same cycle: ack and load still occur, state -> IDLE.
REQ-026 Sample passed in the same cycle as a restart-causing capture shall still be output (out_valid one cycle later).
REQ-027 Counters shall saturate/stop, never wrap, in all states.

Reset
REQ-028 On rst=1, asynchronously: state=IDLE, all clears=1, cfg_ack=0, out_valid=0, out_data=0, cic_order=3'd2, decim_ratio=0, bypass_stg2=0, bypass_noise_gate=0, counters=0.
REQ-029 rst asserted mid-sequence shall abort immediately to reset values; no ack pending after release.
REQ-030 After rst release, first transition out of IDLE no earlier than the first clock edge with enable=1.

Verification
REQ-031 Startup: rst release, enable=1 -> clears high 4 cycles in CLEAR, 8 be_valid pulses dropped, 9th pulse data 16'h1234 -> out_valid with out_data=16'h1234 one cycle later.
REQ-032 Reconfig in RUN: cfg_req with cfg_cic_order=5, decim_ratio=3 -> cfg_ack one cycle later, cic_order=5, decim_ratio=3, state=CLEAR, clears high 4 cycles, 8 more samples dropped.
REQ-033 enable fall in SETTLE after 3 drops -> IDLE next cycle, clears high; re-enable -> full 4-cycle CLEAR and full 8 drops.
REQ-034 Capture in IDLE (enable=0) with bypass_stg2=1 -> ack, bypass_stg2=1, state stays IDLE, no clear deassertion.
REQ-035 DISCARD=0 build: be_valid on first SETTLE cycle dropped, first RUN-cycle sample passed with 1-cycle latency.
REQ-036 rst pulse in RUN during be_valid -> out_valid=0 and all REQ-028 values immediately, no ack emitted.
